frac_out_accum: RTL and testbench
=================================

Name: frac_out_accum

Overview:
- Downstream consumer of the deformed fractional-derivative stage.
- Detects each new derivative sample by a change on that stage's toggle indicator, then rescales it by the time step (derivative output carries a ×100 = 1/step factor).
- Accumulates the rescaled value into a saturating Q8.24 running integral (Euler reconstruction of the operator's result).
- Delivers each updated integral through a small FIFO with a valid/ready handshake.

Parameters:
- DATA_W, 32: sample and accumulator width, signed Q8.24.
- FRAC, 24: fractional bits.
- STEP, 167772: time step 0.01 in Q.24.
- FIFO_DEPTH, 4: output FIFO entries, power of two, at least 2.
- CNT_W, 16: width of the sample and drop counters.

Ports:
- clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  signed derivative sample from the upstream stage.
- in_toggle  in  1  upstream indicator; every change marks a new in_data.
- acc_clr  in  1  synchronous clear of the integral, flags and counters.
- out_data  out  DATA_W  FIFO head: integral value after a sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- out_sat  out  1  sticky: the integral has clipped.
- drop_flag  out  1  sticky: a result was lost because the FIFO was full.
- sample_cnt  out  CNT_W  samples accumulated, wraps modulo 2^CNT_W.
- drop_cnt  out  CNT_W  results not enqueued, saturates at all-ones.

Behaviour:
- Reset (Rst_n low, asynchronous): everything is zero.
  - Accumulator, pipeline and tog_q cleared; FIFO empty.
  - out_data = 0, out_valid = 0, out_sat = 0, drop_flag = 0, sample_cnt = 0, drop_cnt = 0.
  - In-flight samples are discarded. Upstream also starts its toggle at 0.
- Detection: tog_q registers in_toggle. A sample is "new" when in_toggle != tog_q at a rising edge.
  - At most one sample per cycle.
  - A toggle held constant produces no new samples.
- S1 (edge N, new sample): p1 = signed in_data × signed STEP, full 2*DATA_W-bit product, v1 = 1.
- S2 (edge N+1, v1): r2 = p1 arithmetic-shifted right by FRAC, truncated toward −inf; range-check to DATA_W signed.
- Accumulate (edge N+2, v2):
  - sum = acc + r2 computed at DATA_W+1 bits.
  - sum > 2^(DATA_W-1)−1: acc = max and out_sat set.
  - sum < −2^(DATA_W-1): acc = min and out_sat set.
  - Otherwise acc = sum.
  - On the same edge: sample_cnt increments and the new acc is written to the FIFO.
- Latency: toggle seen at edge N → FIFO write at N+2 → out_valid high after N+2 when the FIFO was empty. Throughput is one sample per cycle.
- FIFO:
  - Pop on out_valid && out_ready.
  - out_data is combinational from the head entry; it holds its value while out_valid && !out_ready.
  - Push while full: acc still updates; the result is not stored; drop_cnt increments (saturating); drop_flag is set.
  - Push and pop in the same cycle while full: both occur, no drop.
  - Pop when empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH. Occupancy uses a count register or one extra pointer bit.
- acc_clr (synchronous, priority over accumulation):
  - acc, out_sat, drop_flag, sample_cnt and drop_cnt go to 0.
  - A result reaching accumulate on the same edge is discarded: not added, not enqueued, not counted.
  - S1/S2 contents advance normally. FIFO contents are kept.
- Reset deasserted mid-stream: the first new sample is detected only on a change of in_toggle relative to 0.

Decomposition:
- Shared package frac_pkg holds:
  - FRAC, DATA_W.
  - STEP_Q24 = 167772, ALPHA_Q24 = 8388608, STEP_BETA_Q24 = 16861102.
  - SAT_MAX / SAT_MIN constants.
  - A saturating-add function reused by other operator stages.
- One sub-module: frac_sync_fifo.
  - Parameters: DATA_W and FIFO_DEPTH. Signals: clk, Rst_n, push, pop, din, dout, full, empty.
  - Asynchronous reset to empty.

Test Plan:
1. Reset, then in_data = 0x64000000 (100.0) with a single toggle → after 2 edges out_data = 16777200 (0x00FFFFF0); out_valid = 1; sample_cnt = 1.
2. Same sample, then in_data = 0x9C000000 (−100.0) with a second toggle, out_ready = 1 → outputs 16777200 then 0; out_sat = 0.
3. in_data = 0x7FFFFFFF, toggle every cycle, out_ready = 1 → increments of 21474815. Sample 100 gives 2147481500; sample 101 gives 0x7FFFFFFF with out_sat = 1. Further positive samples stay at 0x7FFFFFFF.
4. out_ready = 0 with 6 toggles (FIFO_DEPTH = 4) → 4 entries held; drop_cnt = 2; drop_flag = 1. Then out_ready = 1 → the first four integrals pop in order; out_valid falls after the 4th.
5. acc_clr asserted on the accumulate edge of a +100.0 sample → result discarded; acc = 0. The next +100.0 sample yields 16777200; sample_cnt = 1.
6. Rst_n pulsed low asynchronously mid-burst, between clock edges → all outputs 0 immediately. After release, the next toggle change yields a fresh integral starting from 0.

Source files
------------

// File: rtl/frac_pkg.sv
// Shared constants and helpers for the fractional-operator datapath stages.
// Fixed-point format throughout is signed Q8.24.
package frac_pkg;

    localparam int DATA_W        = 32;
    localparam int FRAC          = 24;
    localparam int STEP_Q24      = 167772;
    localparam int ALPHA_Q24     = 8388608;
    localparam int STEP_BETA_Q24 = 16861102;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Result of a saturating add: clipped value plus a flag telling whether it clipped.
    typedef struct packed {
        logic                     clip;
        logic signed [DATA_W-1:0] val;
    } sat_res_t;

    // One guard bit is enough: overflow shows as a disagreement between the two top bits.
    function automatic sat_res_t sat_add(input logic signed [DATA_W-1:0] a,
                                         input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] sum;
        sat_res_t               r;
        sum    = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        r.clip = sum[DATA_W] ^ sum[DATA_W-1];
        if (!r.clip)
            r.val = sum[DATA_W-1:0];
        else if (sum[DATA_W])
            r.val = SAT_MIN;
        else
            r.val = SAT_MAX;
        return r;
    endfunction

endpackage

// File: rtl/frac_sync_fifo.sv
// Small synchronous FIFO holding integral results for the downstream consumer.
// Head entry is presented combinationally; an empty FIFO presents zero.
module frac_sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              wr_en;
    logic              rd_en;

    // A push into a full FIFO only lands when a pop frees the head on the same edge.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frac_out_accum.sv
// Euler reconstruction of the fractional operator's output: each new derivative
// sample (flagged by a toggle change) is scaled by the time step and added into a
// saturating Q8.24 running integral, which is then queued for the consumer.
module frac_out_accum #(
    parameter int DATA_W     = 32,
    parameter int FRAC       = 24,
    parameter int STEP       = 167772,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     Rst_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_toggle,
    input  logic                     acc_clr,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sat,
    output logic                     drop_flag,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    import frac_pkg::*;

    localparam logic signed [DATA_W-1:0] STEP_S  = DATA_W'(STEP);
    localparam logic signed [DATA_W-1:0] ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [2*DATA_W-1:0] sext2(input logic signed [DATA_W-1:0] x);
        return {{DATA_W{x[DATA_W-1]}}, x};
    endfunction

    // Drop the step's fractional bits (floor) and clamp back into the sample width.
    function automatic logic signed [DATA_W-1:0] shift_sat(input logic signed [2*DATA_W-1:0] p);
        logic signed [2*DATA_W-1:0] s;
        s = p >>> FRAC;
        if (s > sext2(ACC_MAX))
            return ACC_MAX;
        else if (s < sext2(ACC_MIN))
            return ACC_MIN;
        else
            return s[DATA_W-1:0];
    endfunction

    logic                       tog_q;
    logic                       new_smp;
    logic signed [2*DATA_W-1:0] prod_p1;
    logic                       vld_p1;
    logic signed [DATA_W-1:0]   res_p2;
    logic                       vld_p2;
    logic signed [DATA_W-1:0]   acc;
    sat_res_t                   acc_nxt;
    logic                       push;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [DATA_W-1:0]          fifo_dout;

    assign new_smp = (in_toggle != tog_q);

    // Stage 1: detect a fresh sample and form the full-width step product.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tog_q   <= 1'b0;
            vld_p1  <= 1'b0;
            prod_p1 <= '0;
        end else begin
            tog_q  <= in_toggle;
            vld_p1 <= new_smp;
            if (new_smp)
                prod_p1 <= sext2(in_data) * sext2(STEP_S);
        end
    end

    // Stage 2: rescale the product back to Q8.24.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                res_p2 <= shift_sat(prod_p1);
        end
    end

    // Stage 3: accumulate, enqueue and account; a clear wins over a sample arriving now.
    assign acc_nxt = sat_add(acc, res_p2);
    assign push    = vld_p2 && !acc_clr;

    // Integral, sticky flags and counters.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc        <= '0;
            out_sat    <= 1'b0;
            drop_flag  <= 1'b0;
            sample_cnt <= '0;
            drop_cnt   <= '0;
        end else if (acc_clr) begin
            acc        <= '0;
            out_sat    <= 1'b0;
            drop_flag  <= 1'b0;
            sample_cnt <= '0;
            drop_cnt   <= '0;
        end else if (vld_p2) begin
            acc        <= acc_nxt.val;
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (acc_nxt.clip)
                out_sat <= 1'b1;
            if (fifo_full && !out_ready) begin
                drop_flag <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    frac_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Rst_n (Rst_n),
        .push  (push),
        .pop   (out_ready),
        .din   (acc_nxt.val),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_data  = fifo_dout;
    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_frac_out_accum.sv
// Self-checking bench for frac_out_accum: table of single-step samples plus
// hand-written sequences for saturation, FIFO overflow, clear and async reset.
module tb_frac_out_accum;

    logic        clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic [31:0] in_data;
    logic        in_toggle;
    logic        acc_clr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sat;
    logic        drop_flag;
    logic [15:0] sample_cnt;
    logic [15:0] drop_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    frac_out_accum dut (
        .clk        (clk),
        .Rst_n      (Rst_n),
        .in_data    (in_data),
        .in_toggle  (in_toggle),
        .acc_clr    (acc_clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sat    (out_sat),
        .drop_flag  (drop_flag),
        .sample_cnt (sample_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d);
        in_data   = d;
        in_toggle = ~in_toggle;
        step(1);
    endtask

    task automatic clear();
        acc_clr = 1'b1;
        step(1);
        acc_clr = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got=%0d pending results expected=0", nm, sb.size());
            sb.delete();
        end
        step(3);
    endtask

    // Scoreboard: every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (Rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got=%0h expected=none", out_data);
            end else begin
                mon_exp = sb.pop_front();
                if (out_data !== mon_exp) begin
                    bad++;
                    $display("FAIL out_data: got=%0h expected=%0h", out_data, mon_exp);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{32'h01000000, 32'd167772};
        vecs[1] = '{32'hFF000000, 32'd0};
        vecs[2] = '{32'h00000064, 32'd0};
        vecs[3] = '{32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[4] = '{32'h80000000, 32'hFEB851FF};
        vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFE};
        vecs[6] = '{32'h00000002, 32'hFFFFFFFE};
        vecs[7] = '{32'h64000000, 32'd16777198};

        in_data   = '0;
        in_toggle = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        #1 Rst_n = 1'b0;
        #11;
        chk("reset_flags", {out_valid, out_sat, drop_flag}, 0);
        chk("reset_data", out_data, 0);
        chk("reset_cnts", {sample_cnt, drop_cnt}, 0);
        Rst_n = 1'b1;
        step(2);

        // Single +100.0 sample: latency and value.
        send(32'h64000000);
        step(1);
        chk("latency_n1_valid", out_valid, 0);
        step(1);
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 32'd16777200);
        chk("first_cnt", sample_cnt, 1);
        sb.push_back(32'd16777200);

        // -100.0 brings the integral back to zero.
        out_ready = 1'b1;
        send(32'h9C000000);
        sb.push_back(32'd0);
        drain("pair");
        chk("pair_sat", out_sat, 0);
        chk("pair_cnt", sample_cnt, 2);

        // Table of back-to-back samples, including truncation toward -inf.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].din);
            sb.push_back(vecs[i].exp);
        end
        drain("table");
        chk("table_cnt", sample_cnt, 10);

        // Positive saturation.
        clear();
        for (int k = 1; k <= 100; k++) begin
            send(32'h7FFFFFFF);
            sb.push_back(32'(k * 21474815));
        end
        drain("ramp");
        chk("ramp_nosat", out_sat, 0);
        for (int k = 101; k <= 105; k++) begin
            send(32'h7FFFFFFF);
            sb.push_back(32'h7FFFFFFF);
        end
        drain("clip");
        chk("clip_sat", out_sat, 1);
        chk("clip_cnt", sample_cnt, 105);

        // FIFO overflow with a stalled consumer.
        clear();
        chk("clr_sat", out_sat, 0);
        chk("clr_cnt", sample_cnt, 0);
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            send(32'h01000000);
            if (k <= 4)
                sb.push_back(32'(k * 167772));
        end
        step(3);
        chk("ovf_drop_cnt", drop_cnt, 2);
        chk("ovf_drop_flag", drop_flag, 1);
        chk("ovf_sample_cnt", sample_cnt, 6);
        chk("ovf_head_hold", {out_valid, out_data}, {1'b1, 32'd167772});
        out_ready = 1'b1;
        drain("ovf");
        chk("ovf_empty", out_valid, 0);

        // Clear coinciding with the accumulate edge discards that sample.
        clear();
        send(32'h64000000);
        step(1);
        acc_clr = 1'b1;
        step(1);
        acc_clr = 1'b0;
        step(3);
        chk("clr_discard_cnt", sample_cnt, 0);
        chk("clr_discard_valid", out_valid, 0);
        chk("clr_discard_drop", drop_flag, 0);
        send(32'h64000000);
        sb.push_back(32'd16777200);
        drain("post_clr");
        chk("post_clr_cnt", sample_cnt, 1);

        // Asynchronous reset between edges in the middle of a burst.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(32'h01000000);
        step(3);
        chk("pre_rst_valid", out_valid, 1);
        #2;
        Rst_n     = 1'b0;
        in_toggle = 1'b0;
        #1;
        chk("arst_flags", {out_valid, out_sat, drop_flag}, 0);
        chk("arst_data", out_data, 0);
        chk("arst_cnts", {sample_cnt, drop_cnt}, 0);
        #2;
        Rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1);
        chk("post_rst_idle", {out_valid, sample_cnt}, 0);
        out_ready = 1'b1;
        send(32'h64000000);
        sb.push_back(32'd16777200);
        drain("post_rst");
        chk("post_rst_cnt", sample_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
